// File: rtl/bitcoin_hash_mp.sv
// rtl/bitcoin_hash_mp.sv - multi-lane double-SHA-256 nonce search engine (optional early exit: BITCOIN_HASH_MP_EARLY_EXIT_EN)
module bitcoin_hash_mp #(
    parameter int NUM_NONCES = 16,
    parameter int NUM_LANES  = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [15:0] message_addr,
    input  logic [15:0] output_addr,
    input  logic [31:0] nonce_base,
    input  logic [31:0] target,
    output logic        done,
    output logic        busy,
    output logic        found,
    output logic [31:0] found_nonce,
    output logic        mem_clk,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [31:0] mem_write_data,
    input  logic [31:0] mem_read_data
);

    localparam int NUM_GROUPS = NUM_NONCES / NUM_LANES;

`ifdef BITCOIN_HASH_MP_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [31:0] IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam logic [31:0] K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_PH1, S_PH2, S_PH3, S_WRITE, S_DONE
    } state_t;

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    state_t      state_q, state_d;
    logic [6:0]  cnt;
    logic [6:0]  cnt_m1;
    logic [5:0]  rnd;
    logic [31:0] gcnt;
    logic [31:0] base_idx;
    logic [31:0] grp_idx;
    logic [15:0] msg_q;
    logic [15:0] out_q;
    logic [31:0] nonce_q;
    logic [31:0] target_q;
    logic        last_grp;
    logic        hit;
    logic [31:0] wr_h0;

    logic [31:0] hdr_q [19];
    logic [31:0] mid_q [8];
    logic [31:0] st_q  [NUM_LANES][8];
    logic [31:0] win_q [NUM_LANES][16];
    logic [31:0] dig_q [NUM_LANES][8];
    logic [31:0] h0_q  [NUM_LANES];
    logic [31:0] nst   [NUM_LANES][8];
    logic [31:0] wnew  [NUM_LANES];

    assign mem_clk  = clk;
    assign cnt_m1   = cnt - 7'd1;
    assign rnd      = cnt_m1[5:0];
    assign base_idx = gcnt * 32'(NUM_LANES);
    assign grp_idx  = base_idx + {25'd0, cnt};
    assign last_grp = (gcnt == 32'(NUM_GROUPS - 1));

    // One SHA-256 round per lane plus the next message-schedule word from the rolling window
    always_comb begin
        for (int j = 0; j < NUM_LANES; j++) begin
            logic [31:0] t1;
            logic [31:0] t2;
            t1 = st_q[j][7] + big_sigma1(st_q[j][4])
               + ((st_q[j][4] & st_q[j][5]) ^ (~st_q[j][4] & st_q[j][6]))
               + K[rnd] + win_q[j][0];
            t2 = big_sigma0(st_q[j][0])
               + ((st_q[j][0] & st_q[j][1]) ^ (st_q[j][0] & st_q[j][2]) ^ (st_q[j][1] & st_q[j][2]));
            nst[j][0] = t1 + t2;
            nst[j][1] = st_q[j][0];
            nst[j][2] = st_q[j][1];
            nst[j][3] = st_q[j][2];
            nst[j][4] = st_q[j][3] + t1;
            nst[j][5] = st_q[j][4];
            nst[j][6] = st_q[j][5];
            nst[j][7] = st_q[j][6];
            wnew[j]   = small_sigma1(win_q[j][14]) + win_q[j][9]
                      + small_sigma0(win_q[j][1]) + win_q[j][0];
        end
    end

    // Next-state logic; the write-phase lane select and target hit are shared with the datapath
    always_comb begin
        state_d = state_q;
        wr_h0   = '0;
        for (int j = 0; j < NUM_LANES; j++) begin
            if (cnt == 7'(j)) wr_h0 = h0_q[j];
        end
        hit = (state_q == S_WRITE) && (wr_h0 < target_q);
        case (state_q)
            S_IDLE:  if (start) state_d = S_READ;
            S_READ:  if (cnt == 7'd19) state_d = S_PH1;
            S_PH1:   if (cnt == 7'd65) state_d = S_PH2;
            S_PH2:   if (cnt == 7'd65) state_d = S_PH3;
            S_PH3:   if (cnt == 7'd65) state_d = S_WRITE;
            S_WRITE: begin
                if (cnt == 7'(NUM_LANES - 1)) begin
                    if (last_grp || (EARLY_EXIT && (found || hit)))
                        state_d = S_DONE;
                    else
                        state_d = S_PH2;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    // Datapath: header capture, lane rounds, result write-back and target tracking
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt            <= '0;
            gcnt           <= '0;
            msg_q          <= '0;
            out_q          <= '0;
            nonce_q        <= '0;
            target_q       <= '0;
            done           <= 1'b0;
            busy           <= 1'b0;
            found          <= 1'b0;
            found_nonce    <= '0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_write_data <= '0;
            for (int i = 0; i < 19; i++) hdr_q[i] <= '0;
            for (int i = 0; i < 8; i++) mid_q[i] <= '0;
            for (int j = 0; j < NUM_LANES; j++) begin
                h0_q[j] <= '0;
                for (int i = 0; i < 8; i++) begin
                    st_q[j][i]  <= '0;
                    dig_q[j][i] <= '0;
                end
                for (int i = 0; i < 16; i++) win_q[j][i] <= '0;
            end
        end else begin
            cnt    <= (state_d != state_q) ? 7'd0 : cnt + 7'd1;
            mem_we <= 1'b0;
            done   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    busy <= start;
                    if (start) begin
                        msg_q       <= message_addr;
                        out_q       <= output_addr;
                        nonce_q     <= nonce_base;
                        target_q    <= target;
                        found       <= 1'b0;
                        found_nonce <= '0;
                        mem_addr    <= message_addr;
                        gcnt        <= '0;
                    end
                end
                S_READ: begin
                    // Address for word c is on the bus during count c; its data lands at count c+1
                    if (cnt < 7'd18) mem_addr <= msg_q + {9'd0, cnt} + 16'd1;
                    for (int i = 0; i < 19; i++) begin
                        if (cnt != 7'd0 && cnt_m1 == 7'(i)) hdr_q[i] <= mem_read_data;
                    end
                end
                S_PH1, S_PH2, S_PH3: begin
                    if (cnt == 7'd0) begin
                        for (int j = 0; j < NUM_LANES; j++) begin
                            for (int i = 0; i < 16; i++) win_q[j][i] <= '0;
                            case (state_q)
                                S_PH1: begin
                                    for (int i = 0; i < 8; i++) st_q[j][i] <= IV[i];
                                    for (int i = 0; i < 16; i++) win_q[j][i] <= hdr_q[i];
                                end
                                S_PH2: begin
                                    for (int i = 0; i < 8; i++) st_q[j][i] <= mid_q[i];
                                    win_q[j][0]  <= hdr_q[16];
                                    win_q[j][1]  <= hdr_q[17];
                                    win_q[j][2]  <= hdr_q[18];
                                    win_q[j][3]  <= nonce_q + base_idx + 32'(j);
                                    win_q[j][4]  <= 32'h80000000;
                                    win_q[j][15] <= 32'h00000280;
                                end
                                default: begin
                                    for (int i = 0; i < 8; i++) begin
                                        st_q[j][i]  <= IV[i];
                                        win_q[j][i] <= dig_q[j][i];
                                    end
                                    win_q[j][8]  <= 32'h80000000;
                                    win_q[j][15] <= 32'h00000100;
                                end
                            endcase
                        end
                    end else if (cnt <= 7'd64) begin
                        for (int j = 0; j < NUM_LANES; j++) begin
                            for (int i = 0; i < 8; i++) st_q[j][i] <= nst[j][i];
                            for (int i = 0; i < 15; i++) win_q[j][i] <= win_q[j][i + 1];
                            win_q[j][15] <= wnew[j];
                        end
                    end else begin
                        case (state_q)
                            S_PH1: for (int i = 0; i < 8; i++) mid_q[i] <= IV[i] + st_q[0][i];
                            S_PH2: begin
                                for (int j = 0; j < NUM_LANES; j++)
                                    for (int i = 0; i < 8; i++) dig_q[j][i] <= mid_q[i] + st_q[j][i];
                            end
                            default: for (int j = 0; j < NUM_LANES; j++) h0_q[j] <= IV[0] + st_q[j][0];
                        endcase
                    end
                end
                S_WRITE: begin
                    mem_we         <= 1'b1;
                    mem_addr       <= out_q + grp_idx[15:0];
                    mem_write_data <= wr_h0;
                    // Lanes are visited in ascending nonce order, so the first hit is the lowest index
                    if (hit && !found) begin
                        found       <= 1'b1;
                        found_nonce <= nonce_q + grp_idx;
                    end
                    if (state_d != S_WRITE) gcnt <= gcnt + 32'd1;
                end
                S_DONE: begin
                    done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bitcoin_hash_mp.sv
// tb/tb_bitcoin_hash_mp.sv - self-checking bench for bitcoin_hash_mp against a FIPS-style double-SHA model
module tb_bitcoin_hash_mp;

    localparam int NN = 16;
    localparam int NL = 4;
    localparam int NG = NN / NL;
`ifdef BITCOIN_HASH_MP_EARLY_EXIT_EN
    localparam bit EE = 1'b1;
`else
    localparam bit EE = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [15:0] message_addr;
    logic [15:0] output_addr;
    logic [31:0] nonce_base;
    logic [31:0] target;
    logic        done;
    logic        busy;
    logic        found;
    logic [31:0] found_nonce;
    logic        mem_clk;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [31:0] mem_read_data = '0;

    bitcoin_hash_mp #(.NUM_NONCES(NN), .NUM_LANES(NL)) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .message_addr(message_addr), .output_addr(output_addr),
        .nonce_base(nonce_base), .target(target),
        .done(done), .busy(busy), .found(found), .found_nonce(found_nonce),
        .mem_clk(mem_clk), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] IVP = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
    localparam logic [31:0] KT [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    // Bitcoin genesis block header, raw bytes packed big-endian into words 0..18
    logic [31:0] hdr [19] = '{
        32'h01000000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
        32'h3ba3edfd, 32'h7a7b12b2, 32'h7ac72c3e, 32'h67768f61, 32'h7fc81bc3,
        32'h888a5132, 32'h3a9fb8aa, 32'h4b1e5e4a, 32'h29ab5f49, 32'hffff001d
    };

    typedef struct {
        logic [15:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t         exp_q [$];
    logic [31:0] exp_cyc;
    logic        exp_found;
    logic [31:0] exp_fn;
    logic [15:0] cur_msg = 16'h1000;
    logic [31:0] wr_log [logic [15:0]];
    time         start_time = 0;
    bit          in_run = 1'b0;
    logic        prev_done = 1'b0;
    int          pass_cnt = 0;
    int          chk_cnt = 0;

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] compress(input logic [255:0] hs, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        logic [255:0] s, r;
        for (int t = 0; t < 16; t++) w[t] = blk[511 - 32 * t -: 32];
        for (int t = 16; t < 64; t++)
            w[t] = (rr(w[t-2], 17) ^ rr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                 + (rr(w[t-15], 7) ^ rr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
        {a, b, c, d, e, f, g, h} = hs;
        for (int t = 0; t < 64; t++) begin
            t1 = h + (rr(e, 6) ^ rr(e, 11) ^ rr(e, 25)) + ((e & f) ^ (~e & g)) + KT[t] + w[t];
            t2 = (rr(a, 2) ^ rr(a, 13) ^ rr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        s = {a, b, c, d, e, f, g, h};
        for (int i = 0; i < 8; i++) r[255 - 32 * i -: 32] = s[255 - 32 * i -: 32] + hs[255 - 32 * i -: 32];
        return r;
    endfunction

    function automatic logic [31:0] model_h0(input logic [31:0] nonce);
        logic [511:0] b1;
        logic [255:0] mid, dig, fin;
        for (int i = 0; i < 16; i++) b1[511 - 32 * i -: 32] = hdr[i];
        mid = compress(IVP, b1);
        dig = compress(mid, {hdr[16], hdr[17], hdr[18], nonce, 32'h80000000, 320'd0, 32'h00000280});
        fin = compress(IVP, {dig, 32'h80000000, 192'd0, 32'h00000100});
        return fin[255:224];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        chk_cnt++;
        if (act === req) pass_cnt++;
        else $display("FAIL %s: actual=%h required=%h", nm, act, req);
    endtask

    // Expected write stream, found result and done latency for one run
    task automatic prep(input logic [15:0] out, input logic [31:0] base, input logic [31:0] tgt);
        int groups_run;
        logic [31:0] hv;
        wr_t e;
        groups_run = NG;
        exp_found = 1'b0;
        exp_fn = '0;
        for (int g = 0; g < NG && groups_run == NG; g++) begin
            for (int j = 0; j < NL; j++) begin
                hv = model_h0(base + 32'(g * NL + j));
                e.addr = out + 16'(g * NL + j);
                e.data = hv;
                exp_q.push_back(e);
                if (!exp_found && hv < tgt) begin
                    exp_found = 1'b1;
                    exp_fn = base + 32'(g * NL + j);
                end
            end
            if (EE && exp_found) groups_run = g + 1;
        end
        exp_cyc = 32'(87 + groups_run * (132 + NL));
    endtask

    task automatic launch(input logic [15:0] out, input logic [31:0] base, input logic [31:0] tgt, input bit hold);
        @(negedge clk);
        message_addr = cur_msg;
        output_addr = out;
        nonce_base = base;
        target = tgt;
        start = 1'b1;
        @(posedge clk);
        start_time = $time;
        in_run = 1'b1;
        if (!hold) #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        longint cyc;
        seen = 1'b0;
        cyc = 0;
        for (int i = 0; i < 3000 && !seen; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1'b1;
                cyc = longint'(($time - start_time) / 10);
            end
        end
        in_run = 1'b0;
        if (!seen) begin
            chk_cnt++;
            $display("FAIL %s_timeout: done not seen within 3000 cycles, required at cycle %0d", nm, exp_cyc);
            exp_q.delete();
            return;
        end
        chk({nm, "_latency"}, 32'(cyc), exp_cyc);
        chk({nm, "_found"}, {31'd0, found}, {31'd0, exp_found});
        chk({nm, "_found_nonce"}, found_nonce, exp_fn);
        chk({nm, "_writes_left"}, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    task automatic run(input string nm, input logic [15:0] out, input logic [31:0] base, input logic [31:0] tgt);
        prep(out, base, tgt);
        launch(out, base, tgt, 1'b0);
        wait_done(nm);
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, "_done"}, {31'd0, done}, 32'd0);
        chk({nm, "_busy"}, {31'd0, busy}, 32'd0);
        chk({nm, "_found"}, {31'd0, found}, 32'd0);
        chk({nm, "_found_nonce"}, found_nonce, 32'd0);
        chk({nm, "_mem_we"}, {31'd0, mem_we}, 32'd0);
        chk({nm, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
        chk({nm, "_mem_wdata"}, mem_write_data, 32'd0);
    endtask

    // Header memory: registered read, one cycle of latency
    always @(posedge clk) begin
        logic [15:0] off;
        off = mem_addr - cur_msg;
        mem_read_data <= (off < 16'd19) ? hdr[off[4:0]] : 32'hdeadbeef;
    end

    // Per-cycle compare: every write against the model stream, busy during a run, done as a single pulse
    always @(negedge clk) begin
        if (mem_we) begin
            if (exp_q.size() == 0) begin
                chk_cnt++;
                $display("FAIL spurious_write: mem_we=1 addr=%h data=%h, required mem_we=0", mem_addr, mem_write_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", {16'd0, mem_addr}, {16'd0, e.addr});
                chk("wr_data", mem_write_data, e.data);
            end
            wr_log[mem_addr] = mem_write_data;
        end
        if (in_run && reset_n) chk("busy", {31'd0, busy}, 32'd1);
        if (done) chk("done_pulse", {31'd0, prev_done}, 32'd0);
        prev_done = done;
    end

    initial begin
        reset_n = 1'b0;
        start = 1'b0;
        message_addr = '0;
        output_addr = '0;
        nonce_base = '0;
        target = '0;
        repeat (3) @(negedge clk);
        chk_reset_outputs("reset");

        chk("pin_sha_abc", compress(IVP, {32'h61626380, 448'd0, 32'h00000018}) >> 224, 32'hba7816bf);
        chk("pin_sha_empty", compress(IVP, {32'h80000000, 480'd0}) >> 224, 32'he3b0c442);
        chk("pin_genesis", model_h0(32'h1dac2b7c), 32'h6fe28c0a);

        @(negedge clk);
        reset_n = 1'b1;

        run("t0", 16'h2000, 32'h00000000, 32'h00000000);
        run("tmax", 16'h2100, 32'h00000000, 32'hffffffff);
        run("genesis", 16'h2200, 32'h1dac2b7a, 32'h6fe28c0b);
        chk("genesis_dut_h0", wr_log[16'h2202], 32'h6fe28c0a);
        run("wrap", 16'hfff8, 32'hfffffffe, 32'h40000000);

        prep(16'h4000, 32'h12345678, 32'h80000000);
        launch(16'h4000, 32'h12345678, 32'h80000000, 1'b0);
        repeat (232) @(negedge clk);
        in_run = 1'b0;
        exp_q.delete();
        reset_n = 1'b0;
        #1;
        chk_reset_outputs("midreset");
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        run("restart", 16'h4000, 32'h12345678, 32'h80000000);

        prep(16'h3000, 32'd100, 32'h10000000);
        launch(16'h3000, 32'd100, 32'h10000000, 1'b1);
        @(negedge clk);
        output_addr = 16'h3100;
        nonce_base = 32'habcd0000;
        target = 32'hc0000000;
        wait_done("chainA");
        prep(16'h3100, 32'habcd0000, 32'hc0000000);
        @(posedge clk);
        start_time = $time;
        in_run = 1'b1;
        #1 start = 1'b0;
        wait_done("chainB");

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
